// File: rtl/bram_ram_stream_reader.sv
// Read-side streaming master for the BRAM-backed RAM: sweeps an address range
// and presents the words in order on a valid/ready port through a small buffer.
module bram_ram_stream_reader #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_load,
   input  logic [DATA_WIDTH-1:0] mem_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready
);

   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] addr_ptr;
   logic [ADDR_WIDTH:0]   remaining;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic                  inflight;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_d;
   logic [CW:0]           occ;
   logic [IW-1:0]         wr_idx;
   logic                  issue;
   logic                  pop;
   logic                  push;
   logic [DATA_WIDTH-1:0] fifo_q [BUF_DEPTH];

   assign mem_load = 1'b0;
   assign data_out = fifo_q[0];

   // Next state, issue decision and buffer bookkeeping.
   always_comb begin
      state_d     = state_q;
      pop         = data_valid && data_ready;
      push        = inflight;
      occ         = (CW+1)'(count) + (CW+1)'(inflight);
      issue       = (state_q == S_READ) && (remaining != '0) &&
                    (occ < ((CW+1)'(BUF_DEPTH) + (CW+1)'(pop)));
      count_d     = count + CW'(push) - CW'(pop);
      wr_idx      = IW'(count - CW'(pop));
      mem_address = issue ? addr_ptr : mem_addr_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (length == '0) ? S_DONE : S_READ;
         end
         S_READ: begin
            if (issue && (remaining == (ADDR_WIDTH+1)'(1))) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Finish once the final word is being taken and nothing is still coming back.
            if (!inflight && (count_d == '0)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != S_IDLE);
         done    <= (state_d == S_DONE);
      end
   end

   // Address walker, read tracking and shift-style output buffer (entry 0 is the head).
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_ptr   <= '0;
         remaining  <= '0;
         mem_addr_q <= '0;
         inflight   <= 1'b0;
         count      <= '0;
         data_valid <= 1'b0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) fifo_q[i] <= '0;
      end else begin
         if ((state_q == S_IDLE) && start) begin
            addr_ptr  <= base_addr;
            remaining <= length;
         end else if (issue) begin
            addr_ptr   <= addr_ptr + ADDR_WIDTH'(1);
            remaining  <= remaining - (ADDR_WIDTH+1)'(1);
            mem_addr_q <= addr_ptr;
         end
         inflight   <= issue;
         count      <= count_d;
         data_valid <= (count_d != '0);
         if (pop) begin
            for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) fifo_q[i] <= fifo_q[i+1];
         end
         // Written after the shift so a simultaneous push lands in the vacated slot.
         if (push) fifo_q[wr_idx] <= mem_out;
      end
   end

endmodule

// File: tb/tb_bram_ram_stream_reader.sv
// Directed bench for bram_ram_stream_reader with a behavioural synchronous-read RAM.
module tb_bram_ram_stream_reader;

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_address;
   logic          mem_load;
   logic [DW-1:0] mem_out;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          data_ready;

   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] got [$];
   logic [AW-1:0] addr_log [$];
   logic [AW-1:0] log_last;
   bit            log_en = 1'b0;
   bit            ml_seen;
   int            vectors = 0;
   int            errors  = 0;
   int            first_k, last_acc, done_k, done_cnt, busy_cnt;

   bram_ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .mem_address(mem_address),
      .mem_load   (mem_load),
      .mem_out    (mem_out),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_out <= ram[mem_address];

   // Record each new address the RAM samples.
   always @(posedge clk) begin
      if (log_en && (mem_address !== log_last)) begin
         addr_log.push_back(mem_address);
         log_last = mem_address;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // k = 0 is the cycle right after the edge that accepts start.
   task automatic sweep(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                        input int inj_k, input int max_k);
      bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic          pv, pr, dv, dn, r;
      logic [DW-1:0] pd, dd;
      int            end_k;
      got.delete();
      first_k = -1; last_acc = -1; done_k = -1; done_cnt = 0; busy_cnt = 0;
      pv = 1'b0; pr = 1'b0; pd = '0; end_k = -1;
      @(negedge clk);
      base_addr = b; length = l; start = 1'b1; data_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < max_k; k++) begin
         dv = data_valid; dd = data_out; dn = done;
         if (mem_load) ml_seen = 1'b1;
         if (busy) busy_cnt++;
         if (pv && !pr) begin
            chk("hold_valid", 32'(dv), 32'd1);
            chk("hold_data", 32'(dd), 32'(pd));
         end
         if (dn) begin
            done_cnt++;
            done_k = k;
            chk("done_vs_valid", 32'(dv), 32'd0);
            if (end_k < 0) end_k = k + 3;
         end
         if (dv && (first_k < 0)) first_k = k;
         r = (mode == 0) ? 1'b1 : pat[k % 6];
         data_ready = r;
         start = (k == inj_k);
         if (dv && r) begin
            got.push_back(dd);
            last_acc = k;
         end
         pv = dv; pr = r; pd = dd;
         if (k == end_k) break;
         @(negedge clk);
      end
      data_ready = 1'b0;
      start = 1'b0;
      chk("done_once", 32'(done_cnt), 32'd1);
   endtask

   initial begin
      int n;
      int bad;
      reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; data_ready = 1'b0;
      ml_seen = 1'b0;
      for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_addr", 32'(mem_address), 32'd0);
      chk("rst_load", 32'(mem_load), 32'd0);
      reset = 1'b0;

      // Basic four-word sweep at full rate.
      for (int i = 0; i < 4; i++) ram[100+i] = 16'hA000 + DW'(i);
      sweep(14'd100, 15'd4, 0, -1, 40);
      chk("t1_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("t1_word", 32'(got[i]), 32'hA000 + 32'(i));
      chk("t1_first_valid", 32'(first_k), 32'd2);
      chk("t1_done_timing", 32'(done_k), 32'(last_acc + 1));

      // Same sweep under a stalling consumer.
      sweep(14'd100, 15'd4, 1, -1, 60);
      chk("t2_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("t2_word", 32'(got[i]), 32'hA000 + 32'(i));

      // Address wrap at the top of the RAM.
      ram[16382] = 16'h1111; ram[16383] = 16'h2222; ram[0] = 16'h3333;
      addr_log.delete();
      log_last = mem_address;
      log_en = 1'b1;
      sweep(14'd16382, 15'd3, 0, -1, 40);
      log_en = 1'b0;
      chk("t3_count", 32'(got.size()), 32'd3);
      chk("t3_w0", 32'(got[0]), 32'h1111);
      chk("t3_w1", 32'(got[1]), 32'h2222);
      chk("t3_w2", 32'(got[2]), 32'h3333);
      chk("t3_addr_n", 32'(addr_log.size()), 32'd3);
      chk("t3_a0", 32'(addr_log[0]), 32'd16382);
      chk("t3_a1", 32'(addr_log[1]), 32'd16383);
      chk("t3_a2", 32'(addr_log[2]), 32'd0);

      // Zero-length sweep.
      sweep(14'd5, 15'd0, 0, -1, 20);
      chk("t4_count", 32'(got.size()), 32'd0);
      chk("t4_no_valid", 32'(first_k), 32'hFFFF_FFFF);
      chk("t4_done_k", 32'(done_k), 32'd0);
      chk("t4_busy_cycles", 32'(busy_cnt), 32'd1);

      // Reset in the middle of a long sweep, then a fresh short sweep.
      @(negedge clk);
      base_addr = '0; length = 15'd50; start = 1'b1; data_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int k = 0; k < 200; k++) begin
         if (data_valid) n++;
         if (n == 10) break;
         @(negedge clk);
      end
      @(negedge clk);
      chk("t5_accepted", 32'(n), 32'd10);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_valid", 32'(data_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      reset = 1'b0;
      data_ready = 1'b0;
      sweep(14'd0, 15'd2, 0, -1, 30);
      chk("t5_count", 32'(got.size()), 32'd2);
      chk("t5_w0", 32'(got[0]), 32'h3333);
      chk("t5_w1", 32'(got[1]), 32'h0001);

      // Whole-RAM sweep with a stray start in the middle.
      for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
      ml_seen = 1'b0;
      sweep(14'd0, 15'd16384, 0, 5000, 20000);
      bad = 0;
      foreach (got[i]) if (got[i] !== DW'(i)) bad++;
      chk("t6_count", 32'(got.size()), 32'd16384);
      chk("t6_order", 32'(bad), 32'd0);
      chk("t6_mem_load", 32'(ml_seen), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
